// File: rtl/regfile_mp_bypass.sv
// Integer register file for the RV32I core.
// Provides NRD combinational read ports and two synchronous write ports
// (W0 = ALU/writeback, W1 = load return). Reads see same-cycle writes
// through a bypass. A per-register busy scoreboard tracks outstanding loads,
// and a registered tap reports the last effective write.
//
// Ports:
//   Clk, Rst                 clock (rising edge), async active-high reset
//   RdAddr/RdData/RdBusy     NRD read ports, port i at slice i
//   W0En/W0Addr/W0Data       write port 0 (writeback; wins on address clash)
//   W1En/W1Addr/W1Data       write port 1 (load return; clears busy)
//   ResEn/ResAddr            reserve: mark register busy (load issued)
//   DbgWrValid/Addr/Data     registered last-effective-write tap
module regfile_mp_bypass #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NRD*$clog2(NREGS)-1:0] RdAddr,
    output logic [NRD*XLEN-1:0]     RdData,
    output logic [NRD-1:0]          RdBusy,
    input  logic                    W0En,
    input  logic [$clog2(NREGS)-1:0] W0Addr,
    input  logic [XLEN-1:0]         W0Data,
    input  logic                    W1En,
    input  logic [$clog2(NREGS)-1:0] W1Addr,
    input  logic [XLEN-1:0]         W1Data,
    input  logic                    ResEn,
    input  logic [$clog2(NREGS)-1:0] ResAddr,
    output logic                    DbgWrValid,
    output logic [$clog2(NREGS)-1:0] DbgWrAddr,
    output logic [XLEN-1:0]         DbgWrData
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    logic w0_eff;
    logic w1_eff;
    logic res_eff;

    // A write or reserve to reg 0 is dropped when reg 0 is hardwired.
    assign w0_eff  = W0En  && !(ZERO_REG && (W0Addr  == '0));
    assign w1_eff  = W1En  && !(ZERO_REG && (W1Addr  == '0));
    assign res_eff = ResEn && !(ZERO_REG && (ResAddr == '0));

    // Register array: W0 is assigned last so it wins on an address clash.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int r = 0; r < int'(NREGS); r++) begin
                regs[r] <= '0;
            end
        end else begin
            if (w1_eff) begin
                regs[W1Addr] <= W1Data;
            end
            if (w0_eff) begin
                regs[W0Addr] <= W0Data;
            end
        end
    end

    // Busy scoreboard: a new reserve outranks a same-cycle load return.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            busy <= '0;
        end else begin
            for (int r = 0; r < int'(NREGS); r++) begin
                if (res_eff && (ResAddr == AW'(r))) begin
                    busy[r] <= 1'b1;
                end else if (w1_eff && (W1Addr == AW'(r))) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    // Debug tap: addr/data hold when no effective write occurs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            DbgWrValid <= 1'b0;
            DbgWrAddr  <= '0;
            DbgWrData  <= '0;
        end else begin
            DbgWrValid <= w0_eff || w1_eff;
            if (w0_eff) begin
                DbgWrAddr <= W0Addr;
                DbgWrData <= W0Data;
            end else if (w1_eff) begin
                DbgWrAddr <= W1Addr;
                DbgWrData <= W1Data;
            end
        end
    end

    // Read ports with write bypass (W0 before W1 before stored value).
    for (genvar gi = 0; gi < int'(NRD); gi++) begin : g_rd
        logic [AW-1:0] ra;
        logic          zero_hit;
        logic          w0_hit;
        logic          w1_hit;

        assign ra       = RdAddr[gi*AW +: AW];
        assign zero_hit = ZERO_REG && (ra == '0);
        assign w0_hit   = w0_eff && (W0Addr == ra);
        assign w1_hit   = w1_eff && (W1Addr == ra);

        assign RdData[gi*XLEN +: XLEN] = zero_hit ? '0 :
                                         w0_hit   ? W0Data :
                                         w1_hit   ? W1Data :
                                                    regs[ra];

        // A load return arriving this cycle already satisfies the reader.
        assign RdBusy[gi] = !zero_hit && busy[ra] && !w1_hit;
    end

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Directed testbench for regfile_mp_bypass (default parameters).
module tb_regfile_mp_bypass;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NRD  = 2;

    logic                Clk;
    logic                Rst;
    logic [NRD*AW-1:0]   RdAddr;
    logic [NRD*XLEN-1:0] RdData;
    logic [NRD-1:0]      RdBusy;
    logic                W0En;
    logic [AW-1:0]       W0Addr;
    logic [XLEN-1:0]     W0Data;
    logic                W1En;
    logic [AW-1:0]       W1Addr;
    logic [XLEN-1:0]     W1Data;
    logic                ResEn;
    logic [AW-1:0]       ResAddr;
    logic                DbgWrValid;
    logic [AW-1:0]       DbgWrAddr;
    logic [XLEN-1:0]     DbgWrData;

    int total = 0;
    int bad   = 0;

    regfile_mp_bypass #(
        .XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b1)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .RdAddr(RdAddr), .RdData(RdData), .RdBusy(RdBusy),
        .W0En(W0En), .W0Addr(W0Addr), .W0Data(W0Data),
        .W1En(W1En), .W1Addr(W1Addr), .W1Data(W1Data),
        .ResEn(ResEn), .ResAddr(ResAddr),
        .DbgWrValid(DbgWrValid), .DbgWrAddr(DbgWrAddr), .DbgWrData(DbgWrData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        RdAddr[p*AW +: AW] = a;
    endtask

    function automatic logic [31:0] rdd(input int p);
        return RdData[p*XLEN +: XLEN];
    endfunction

    task automatic idle();
        W0En = 1'b0; W1En = 1'b0; ResEn = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; RdAddr = '0;
        W0En = 1'b0; W0Addr = '0; W0Data = '0;
        W1En = 1'b0; W1Addr = '0; W1Data = '0;
        ResEn = 1'b0; ResAddr = '0;
        #12;
        Rst = 1'b0;
        #1;

        // 1: reset state on every register and port
        for (int r = 0; r < 32; r++) begin
            set_rd(0, AW'(r));
            set_rd(1, AW'(31 - r));
            #1;
            chk("rst_rd0", rdd(0), 32'h0);
            chk("rst_rd1", rdd(1), 32'h0);
            chk("rst_busy", 32'(RdBusy), 32'h0);
        end
        chk("rst_dbgv", 32'(DbgWrValid), 32'h0);
        chk("rst_dbga", 32'(DbgWrAddr), 32'h0);
        chk("rst_dbgd", DbgWrData, 32'h0);

        // 2: W0 bypass then stored value, debug tap
        W0En = 1'b1; W0Addr = 5'd5; W0Data = 32'hDEADBEEF;
        set_rd(0, 5'd5); set_rd(1, 5'd6);
        #1;
        chk("w0_bypass", rdd(0), 32'hDEADBEEF);
        chk("w0_other", rdd(1), 32'h0);
        tick(); idle(); #1;
        chk("w0_stored", rdd(0), 32'hDEADBEEF);
        chk("w0_dbgv", 32'(DbgWrValid), 32'h1);
        chk("w0_dbga", 32'(DbgWrAddr), 32'd5);
        chk("w0_dbgd", DbgWrData, 32'hDEADBEEF);

        // 3: reg 0 ignores writes and reserves
        W0En = 1'b1; W0Addr = 5'd0; W0Data = 32'h1234;
        ResEn = 1'b1; ResAddr = 5'd0;
        set_rd(0, 5'd0); set_rd(1, 5'd0);
        #1;
        chk("x0_byp", rdd(0), 32'h0);
        chk("x0_busy0", 32'(RdBusy), 32'h0);
        tick(); idle(); #1;
        chk("x0_rd", rdd(1), 32'h0);
        chk("x0_busy1", 32'(RdBusy), 32'h0);
        chk("x0_dbgv", 32'(DbgWrValid), 32'h0);
        chk("x0_dbga_hold", 32'(DbgWrAddr), 32'd5);
        chk("x0_dbgd_hold", DbgWrData, 32'hDEADBEEF);

        // 4: reserve then load return
        ResEn = 1'b1; ResAddr = 5'd7;
        set_rd(1, 5'd7);
        #1;
        chk("res_same_cyc", 32'(RdBusy[1]), 32'h0);
        tick(); idle(); #1;
        chk("res_busy", 32'(RdBusy[1]), 32'h1);
        W1En = 1'b1; W1Addr = 5'd7; W1Data = 32'hA5A5A5A5;
        #1;
        chk("w1_busy_byp", 32'(RdBusy[1]), 32'h0);
        chk("w1_data_byp", rdd(1), 32'hA5A5A5A5);
        tick(); idle(); #1;
        chk("w1_busy_clr", 32'(RdBusy[1]), 32'h0);
        chk("w1_stored", rdd(1), 32'hA5A5A5A5);
        chk("w1_dbgv", 32'(DbgWrValid), 32'h1);
        chk("w1_dbga", 32'(DbgWrAddr), 32'd7);

        // 5a: W0/W1 same address, W0 wins
        W0En = 1'b1; W0Addr = 5'd3; W0Data = 32'h11;
        W1En = 1'b1; W1Addr = 5'd3; W1Data = 32'h22;
        set_rd(0, 5'd3);
        #1;
        chk("clash_byp", rdd(0), 32'h11);
        tick(); idle(); #1;
        chk("clash_stored", rdd(0), 32'h11);
        chk("clash_dbgd", DbgWrData, 32'h11);
        chk("clash_dbga", 32'(DbgWrAddr), 32'd3);

        // 5b: reserve + load return same reg keeps busy set
        ResEn = 1'b1; ResAddr = 5'd9;
        W1En = 1'b1; W1Addr = 5'd9; W1Data = 32'h99;
        set_rd(1, 5'd9);
        #1;
        chk("resw1_busy_now", 32'(RdBusy[1]), 32'h0);
        tick(); idle(); #1;
        chk("resw1_busy", 32'(RdBusy[1]), 32'h1);
        chk("resw1_data", rdd(1), 32'h99);

        // 5c: W0 does not clear busy
        W0En = 1'b1; W0Addr = 5'd9; W0Data = 32'h77;
        tick(); idle(); #1;
        chk("w0_keeps_busy", 32'(RdBusy[1]), 32'h1);
        chk("w0_x9", rdd(1), 32'h77);

        // 5d: two different addresses written same cycle
        W0En = 1'b1; W0Addr = 5'd4; W0Data = 32'h44;
        W1En = 1'b1; W1Addr = 5'd6; W1Data = 32'h66;
        set_rd(0, 5'd4); set_rd(1, 5'd6);
        #1;
        chk("dual_byp0", rdd(0), 32'h44);
        chk("dual_byp1", rdd(1), 32'h66);
        tick(); idle(); #1;
        chk("dual_st0", rdd(0), 32'h44);
        chk("dual_st1", rdd(1), 32'h66);
        chk("dual_dbga", 32'(DbgWrAddr), 32'd4);
        chk("dual_dbgd", DbgWrData, 32'h44);

        // 6: async reset mid-cycle clears state immediately
        W0En = 1'b1; W0Addr = 5'd10; W0Data = 32'hFF;
        ResEn = 1'b1; ResAddr = 5'd12;
        tick(); idle(); #1;
        set_rd(0, 5'd10); set_rd(1, 5'd12);
        #1;
        chk("pre_rst_x10", rdd(0), 32'hFF);
        chk("pre_rst_busy", 32'(RdBusy[1]), 32'h1);
        Rst = 1'b1;
        #1;
        chk("arst_x10", rdd(0), 32'h0);
        chk("arst_busy", 32'(RdBusy), 32'h0);
        chk("arst_dbgv", 32'(DbgWrValid), 32'h0);
        chk("arst_dbgd", DbgWrData, 32'h0);
        set_rd(1, 5'd9);
        #1;
        chk("arst_x9_busy", 32'(RdBusy[1]), 32'h0);
        // writes during reset are discarded
        W0En = 1'b1; W0Addr = 5'd11; W0Data = 32'hBAD;
        tick(); idle();
        Rst = 1'b0;
        set_rd(0, 5'd11);
        #1;
        chk("rst_drop_w", rdd(0), 32'h0);
        tick(); #1;
        chk("post_rst_dbgv", 32'(DbgWrValid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
